// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with shadowed divisors and transfer acknowledge.
// Optional terminal-count tick outputs are built only when CLKDIV_TICK_OUT_EN is defined.
module clkdiv_multi #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 32768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              div_wr,
    input  logic [2:0]        div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] div_ack,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);

    logic [CNT_W-1:0] w_div_clamp;

    assign w_div_clamp = (div_val < MinDiv) ? MinDiv : div_val;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt, r_div, r_shd;
        logic             r_pend, r_clk, r_ack;
        logic [CNT_W-1:0] w_cnt_nxt, w_div_nxt, w_shd_nxt;
        logic             w_pend_nxt, w_clk_nxt, w_wr_hit, w_wrap, w_xfer;

        assign w_wr_hit = div_wr && (div_ch == 3'(g));
        assign w_wrap   = (r_cnt == (r_div - CNT_W'(1)));

        always_comb begin
            // A write landing on the transfer edge wins; the new shadow waits for the next wrap.
            w_xfer     = r_pend && !w_wr_hit && (!en[g] || w_wrap);
            w_cnt_nxt  = (!en[g] || w_wrap) ? '0 : r_cnt + CNT_W'(1);
            w_div_nxt  = w_xfer ? r_shd : r_div;
            w_shd_nxt  = w_wr_hit ? w_div_clamp : r_shd;
            w_pend_nxt = w_wr_hit || (r_pend && !w_xfer);
            // Decode on next-state values so the flop tracks the counter it is registered with.
            w_clk_nxt  = en[g] && (w_cnt_nxt >= (w_div_nxt - (w_div_nxt >> 1)));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_div  <= DefDiv;
                r_shd  <= DefDiv;
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_ack  <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_div  <= w_div_nxt;
                r_shd  <= w_shd_nxt;
                r_pend <= w_pend_nxt;
                r_clk  <= w_clk_nxt;
                r_ack  <= w_xfer;
            end
        end

        assign clk_out[g] = r_clk;
        assign div_ack[g] = r_ack;

`ifdef CLKDIV_TICK_OUT_EN
        logic r_tick;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tick <= 1'b0;
            end else begin
                r_tick <= en[g] && w_wrap;
            end
        end

        assign tick[g] = r_tick;
`else
        assign tick[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: table-driven divisor vectors plus directed
// sequences for wrap-coincident writes, disable transfer and asynchronous reset.
module tb_clkdiv_multi;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 32768;
`ifdef CLKDIV_TICK_OUT_EN
    localparam int TickPerPeriod = 1;
`else
    localparam int TickPerPeriod = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] en;
    logic              div_wr;
    logic [2:0]        div_ch;
    logic [CNT_W-1:0]  div_val;
    logic [NUM_CH-1:0] div_ack;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clkdiv_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .div_wr (div_wr),
        .div_ch (div_ch),
        .div_val(div_val),
        .div_ack(div_ack),
        .clk_out(clk_out),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Edges seen by untouched channel 1, which runs at the default divisor until the table.
    always @(posedge clk) if (rst_n && en[1]) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int val;
        int hi;
        int lo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_div(input int ch, input int val);
        div_wr  = 1'b1;
        div_ch  = 3'(ch);
        div_val = CNT_W'(val);
        step();
        div_wr  = 1'b0;
    endtask

    task automatic wait_rise(input int ch);
        int n = 0;
        while (clk_out[ch] && n < 40000) begin step(); n++; end
        while (!clk_out[ch] && n < 40000) begin step(); n++; end
        if (n >= 40000) timeout("wait_rise");
    endtask

    // Call at the first high sample; returns at the next rising sample.
    task automatic measure(input int ch, output int hi, output int lo, output int ticks);
        hi = 0;
        lo = 0;
        ticks = 0;
        while (clk_out[ch] && hi < 40000) begin
            if (tick[ch]) ticks++;
            hi++;
            step();
        end
        while (!clk_out[ch] && lo < 40000) begin
            if (tick[ch]) ticks++;
            lo++;
            step();
        end
        if (hi >= 40000 || lo >= 40000) timeout("measure");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, lo, tk, acks, ack_at, highs;

        vecs[0] = '{1, 0, 1, 1};
        vecs[1] = '{1, 1, 1, 1};
        vecs[2] = '{0, 3, 1, 2};
        vecs[3] = '{0, 8, 4, 4};
        vecs[4] = '{1, 7, 3, 4};
        vecs[5] = '{0, 6, 3, 3};

        en      = 2'b11;
        div_wr  = 1'b0;
        div_ch  = 3'd0;
        div_val = '0;
        rst_n   = 1'b0;
        repeat (3) step();
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_ack", div_ack, 0);

        // Default divisor: first rise after 16384 edges, 50% duty over 32768.
        rst_n = 1'b1;
        n = 0;
        while (!clk_out[0] && n < 20000) begin step(); n++; end
        check("def_first_rise", n, 16384);
        measure(0, hi, lo, tk);
        check("def_hi", hi, 16384);
        check("def_lo", lo, 16384);
        check("def_ticks", tk, TickPerPeriod);
        check("ch1_model_a", clk_out[1], ((cyc % 32768) >= 16384) ? 1 : 0);

        // Mid-period write to ch0 takes effect at the wrap; invalid channel write ignored.
        write_div(0, 5);
        write_div(2, 3);
        n = 0;
        while (!div_ack[0] && n < 20000) begin step(); n++; end
        check("ack0_latency", n, 16382);
        check("ack0_clk_low", clk_out[0], 0);
        check("ack1_quiet", div_ack[1], 0);
        check("ch1_model_b", clk_out[1], ((cyc % 32768) >= 16384) ? 1 : 0);
        step();
        check("ack0_one_pulse", div_ack[0], 0);
        wait_rise(0);
        measure(0, hi, lo, tk);
        check("d5_hi", hi, 2);
        check("d5_lo", lo, 3);
        check("d5_ticks", tk, TickPerPeriod);
        check("ch1_model_c", clk_out[1], ((cyc % 32768) >= 16384) ? 1 : 0);

        // Table: write, drop enable to force transfer, re-enable and measure.
        for (int i = 0; i < 6; i++) begin
            write_div(vecs[i].ch, vecs[i].val);
            en[vecs[i].ch] = 1'b0;
            step();
            check("tbl_dis_ack", div_ack[vecs[i].ch], 1);
            check("tbl_dis_clk", clk_out[vecs[i].ch], 0);
            check("tbl_dis_tick", tick[vecs[i].ch], 0);
            en[vecs[i].ch] = 1'b1;
            step();
            check("tbl_ack_clear", div_ack[vecs[i].ch], 0);
            check("tbl_restart_tick", tick[vecs[i].ch], 0);
            wait_rise(vecs[i].ch);
            measure(vecs[i].ch, hi, lo, tk);
            check("tbl_hi", hi, vecs[i].hi);
            check("tbl_lo", lo, vecs[i].lo);
            check("tbl_ticks", tk, TickPerPeriod);
        end

        // ch0 at D=6: write 7 mid-period, then 9 on the wrap edge; transfer one period later.
        n = 0;
        while (clk_out[0] && n < 100) begin step(); n++; end
        if (n >= 100) timeout("d6_fall");
        write_div(0, 7);
        acks = 0;
        repeat (4) begin
            step();
            if (div_ack[0]) acks++;
        end
        write_div(0, 9);
        ack_at = -1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            if (div_ack[0]) begin
                acks++;
                ack_at = k;
            end
        end
        check("dbl_ack_count", acks, 1);
        check("dbl_ack_at", ack_at, 6);
        wait_rise(0);
        measure(0, hi, lo, tk);
        check("d9_hi", hi, 4);
        check("d9_lo", lo, 5);

        // Asynchronous reset with ch1 high and a divisor pending.
        wait_rise(1);
        write_div(1, 5);
        check("pre_rst_ch1_high", clk_out[1], 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clk", clk_out, 0);
        check("async_rst_ack", div_ack, 0);
        check("async_rst_tick", tick, 0);
        step();
        rst_n = 1'b1;
        acks = 0;
        highs = 0;
        repeat (40) begin
            step();
            if (div_ack != 0) acks++;
            if (clk_out != 0) highs++;
        end
        check("post_rst_acks", acks, 0);
        check("post_rst_highs", highs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
CLKDIV_MULTI -- requirements
Module: clkdiv_multi

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 16, counter and divisor width in bits (2..32).
REQ-003 Parameter DEF_DIV, default 32768, per-channel divisor loaded at reset (2..2^CNT_W-1).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  NUM_CH  per-channel run enable.
REQ-007 div_wr  input  1  divisor write strobe, one cycle per write.
REQ-008 div_ch  input  3  channel index for div_wr.
REQ-009 div_val  input  CNT_W  divisor value for div_wr.
REQ-010 div_ack  output  NUM_CH  one-cycle pulse per channel when a written divisor takes effect.
REQ-011 clk_out  output  NUM_CH  divided square-wave outputs, registered.
REQ-012 tick  output  NUM_CH  one-cycle terminal-count pulses, registered.

Function
REQ-013 Each channel SHALL hold active divisor D, shadow divisor S, pending flag P, and counter cnt (CNT_W bits).
REQ-014 With en[i]=1, cnt SHALL step 0,1,...,D-1,0 (wrap), one step per clk edge.
REQ-015 With en[i]=0, cnt SHALL clear to 0 and clk_out[i], tick[i] SHALL be 0 on the next edge; re-enable restarts from cnt=0.
REQ-016 clk_out[i] SHALL be 1 exactly while cnt >= D - floor(D/2): period D cycles, high floor(D/2), low ceil(D/2).
REQ-017 clk_out[i] SHALL be glitch-free: driven directly from a flop, never from combinational decode.
REQ-018 div_wr with div_ch < NUM_CH SHALL write S of that channel and set P on the next edge; div_ch >= NUM_CH SHALL be ignored, no ack.
REQ-019 div_val of 0 or 1 SHALL be stored as 2 (clamp).
REQ-020 Pending S SHALL transfer to D only at a wrap edge (cnt D-1 -> 0), or on the next edge if en[i]=0; P clears on transfer.
REQ-021 div_ack[i] SHALL pulse high for exactly one cycle, the cycle after transfer.
REQ-022 A write to channel i on the same edge as a channel-i wrap SHALL NOT transfer; S takes the new value, P stays set, transfer at the following wrap.
REQ-023 Multiple writes before a transfer SHALL overwrite S; only the last value is applied and only one div_ack pulse issued.
REQ-024 Channels SHALL be fully independent; a write to one channel SHALL not perturb another channel's cnt or outputs.

Reset
REQ-025 rst_n=0 SHALL immediately force cnt=0, D=S=DEF_DIV, P=0, clk_out=0, tick=0, div_ack=0 on all channels, regardless of clk.
REQ-026 Reset mid-period or with P set SHALL discard the pending divisor; no div_ack after release.
REQ-027 First counting edge SHALL be the first rising clk edge after rst_n deasserts with en[i]=1.

Configuration
REQ-028 Macro CLKDIV_TICK_OUT_EN defined: tick[i] SHALL pulse high for one cycle in each cycle where cnt=0 following a wrap (not following reset or re-enable).
REQ-029 Macro CLKDIV_TICK_OUT_EN undefined: tick SHALL be tied to 0 with no tick logic synthesised; all other behaviour unchanged.

Verification
REQ-030 Reset, en=2'b11, DEF_DIV=32768 -> clk_out[0] first rises 16384 cycles after first edge, period 32768, duty 50%.
REQ-031 Write div_ch=0, div_val=5 mid-period -> new period begins at next wrap; clk_out[0] low 3 high 2; div_ack[0] one pulse one cycle after wrap; channel 1 unaffected.
REQ-032 Write div_val=0 to channel 1 -> behaves as D=2: clk_out[1] toggles every cycle; with CLKDIV_TICK_OUT_EN, tick[1] every 2 cycles.
REQ-033 Writes 7 then 9 to channel 0 before wrap, second write coincident with wrap -> no transfer at that wrap, D=9 at following wrap, exactly one div_ack.
REQ-034 Drop en[0] mid-period with P set -> cnt=0, clk_out[0]=0 next edge, D=S transferred and div_ack[0] pulses; re-enable restarts at cnt=0, no tick.
REQ-035 Assert rst_n=0 between clk edges with P set -> outputs 0 immediately, D=DEF_DIV, no div_ack after release.
